// File: rtl/cxl_wr_arbiter.sv
// cxl_wr_arbiter: arbitrates evict (req0) and flush (req1) single-beat writes onto one AXI AW/W/B port.
// Build option: define CXL_WR_ARB_FIXED_PRIO_EN to give requester 0 strict priority instead of round-robin.
//
// state | meaning
// IDLE  | waiting for an eligible requester; grant is offered combinationally
// SEND  | latched write driven on AW and W until both handshakes complete

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif

module cxl_wr_arbiter #(
    parameter int                  ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int                  DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int                  ID_WIDTH   = `AXI_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] BASE_ID    = ID_WIDTH'(`AXI_ID),
    parameter int                  MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    output logic                  req0_ready_o,
    output logic                  req0_bdone_o,
    input  logic                  req1_valid_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    output logic                  req1_ready_o,
    output logic                  req1_bdone_o,
    output logic [ID_WIDTH-1:0]   awid_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ID_WIDTH-1:0]   wid_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [ID_WIDTH-1:0]   bid_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic                  bid_err_o
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam int                  CW    = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]       MAX_C = CW'(MAX_OUT);
    localparam logic [ID_WIDTH-1:0] ID0   = BASE_ID;
    localparam logic [ID_WIDTH-1:0] ID1   = BASE_ID + ID_WIDTH'(1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q [2];
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  grant_q, aw_done_q, w_done_q;
    logic                  bdone0_q, bdone1_q, bid_err_q;
    logic                  elig0, elig1, gnt_any, gnt_sel, grant_fire;
    logic                  aw_fire, w_fire, send_done;
    logic [1:0]            cnt_inc, b_hit;
`ifndef CXL_WR_ARB_FIXED_PRIO_EN
    logic                  rr_q;    // 1: requester 1 preferred on the next tie
`endif

    assign elig0   = req0_valid_i && (cnt_q[0] < MAX_C);
    assign elig1   = req1_valid_i && (cnt_q[1] < MAX_C);
    assign gnt_any = elig0 || elig1;
`ifdef CXL_WR_ARB_FIXED_PRIO_EN
    assign gnt_sel = !elig0;
`else
    assign gnt_sel = (elig0 && elig1) ? rr_q : !elig0;
`endif

    assign awvalid_o = (state_q == SEND) && !aw_done_q;
    assign wvalid_o  = (state_q == SEND) && !w_done_q;
    assign aw_fire   = awvalid_o && awready_i;
    assign w_fire    = wvalid_o && wready_i;
    assign send_done = (state_q == SEND) && (aw_done_q || aw_fire) && (w_done_q || w_fire);
    assign cnt_inc   = {send_done && grant_q, send_done && !grant_q};

    // A B for a requester with nothing outstanding is treated as a stray ID.
    assign b_hit[0] = bvalid_i && rst_n && (bid_i == ID0) && (cnt_q[0] != '0);
    assign b_hit[1] = bvalid_i && rst_n && (bid_i == ID1) && (cnt_q[1] != '0);

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        case (state_q)
            IDLE: if (gnt_any) begin
                state_d    = SEND;
                grant_fire = 1'b1;
            end
            SEND: if (send_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready_o = rst_n && grant_fire && !gnt_sel;
    assign req1_ready_o = rst_n && grant_fire && gnt_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            id_q      <= '0;
            grant_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            bdone0_q  <= 1'b0;
            bdone1_q  <= 1'b0;
            bid_err_q <= 1'b0;
`ifndef CXL_WR_ARB_FIXED_PRIO_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                addr_q    <= gnt_sel ? req1_addr_i : req0_addr_i;
                data_q    <= gnt_sel ? req1_data_i : req0_data_i;
                id_q      <= gnt_sel ? ID1 : ID0;
                grant_q   <= gnt_sel;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_fire) aw_done_q <= 1'b1;
                if (w_fire)  w_done_q  <= 1'b1;
            end
`ifndef CXL_WR_ARB_FIXED_PRIO_EN
            if (send_done) rr_q <= !grant_q;
`endif
            for (int i = 0; i < 2; i++) begin
                if (cnt_inc[i] && !b_hit[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
                else if (!cnt_inc[i] && b_hit[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
            end
            bdone0_q  <= b_hit[0];
            bdone1_q  <= b_hit[1];
            bid_err_q <= bid_err_q || (bvalid_i && (b_hit == 2'b00));
        end
    end

    assign awid_o       = id_q;
    assign wid_o        = id_q;
    assign awaddr_o     = addr_q;
    assign wdata_o      = data_q;
    assign bready_o     = rst_n;
    assign req0_bdone_o = bdone0_q;
    assign req1_bdone_o = bdone1_q;
    assign bid_err_o    = bid_err_q;

endmodule

// File: doc/cxl_wr_arbiter.md
Name: cxl_wr_arbiter

Overview:
- Two-requester write arbiter in front of the CXL controller AXI write port (AW/W/B, single-beat).
- Requester 0 is the evict writeback path; requester 1 is the flush/dirty-writeback path.
- Grants one requester per transaction and drives AW and W with independent handshakes.
- Tracks per-requester outstanding writes and routes B responses back by ID.

Parameters:
ADDR_WIDTH, `AXI_ADDR_WIDTH, address width
DATA_WIDTH, `AXI_DATA_WIDTH, write data width (one beat)
ID_WIDTH, `AXI_ID_WIDTH, AXI ID width
BASE_ID, `AXI_ID, ID for requester 0; requester 1 uses BASE_ID+1
MAX_OUT, 4, max outstanding (unacknowledged) writes per requester, range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
req0_valid_i  in  1  requester 0 has a write pending
req0_addr_i  in  ADDR_WIDTH  requester 0 address
req0_data_i  in  DATA_WIDTH  requester 0 data
req0_ready_o  out  1  requester 0 write accepted this cycle
req0_bdone_o  out  1  one-cycle pulse when requester 0's B arrives
req1_valid_i / req1_addr_i / req1_data_i / req1_ready_o / req1_bdone_o  same for requester 1
awid_o  out  ID_WIDTH  AW ID
awaddr_o  out  ADDR_WIDTH  AW address
awvalid_o  out  1  AW valid
awready_i  in  1  AW ready
wid_o  out  ID_WIDTH  W ID (equals awid_o)
wdata_o  out  DATA_WIDTH  W data
wvalid_o  out  1  W valid
wready_i  in  1  W ready
bid_i  in  ID_WIDTH  B ID
bvalid_i  in  1  B valid
bready_o  out  1  B ready
bid_err_o  out  1  sticky: B received with unknown ID or with zero outstanding

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all valid/ready/pulse outputs 0; awaddr/wdata/awid/wid regs 0; outstanding counters 0; round-robin pointer = requester 0 preferred; bid_err_o=0. A reset mid-transaction abandons it; no completion pulse.
- Eligible requester: reqN_valid_i=1 and outstanding[N] < MAX_OUT.
- IDLE:
  - If any requester is eligible, grant one. If both are eligible, grant the one not granted last (round-robin); after reset, grant 0.
  - reqN_ready_o=1 combinationally in the same cycle, only for the granted requester.
  - Latch addr, data and ID = BASE_ID+N; clear aw_done and w_done; go to SEND.
- SEND:
  - awvalid_o = !aw_done; wvalid_o = !w_done; payload stays stable.
  - aw_done sets on awvalid_o & awready_i; w_done sets on wvalid_o & wready_i, in either order or in the same cycle.
  - When both are done (registered or completing this cycle): return to IDLE, increment outstanding[grant], set round-robin pointer to prefer the other requester.
  - reqN_ready_o = 0 throughout SEND.
- Latency: valid at cycle t → ready at t, awvalid_o/wvalid_o at t+1; with AXI always ready, peak issue rate is 1 write per 2 cycles.
- B channel:
  - bready_o=1 whenever out of reset, independent of state.
  - On bvalid_i with bid_i = BASE_ID+N and outstanding[N] > 0: decrement outstanding[N]; pulse reqN_bdone_o the next cycle (registered).
  - If bid_i matches neither requester, or the matching counter is 0: no counter change, no pulse, set bid_err_o (sticky until reset).
- Issue completion and B for the same requester in the same cycle: counter unchanged, bdone still pulses.
- Counter at MAX_OUT: that requester is ineligible; the other may still be granted. Counter never wraps.
- Counter width: $clog2(MAX_OUT+1).

Optional Feature:
- Macro: CXL_WR_ARB_FIXED_PRIO_EN.
- Defined: requester 0 (evict) always wins when both are eligible, and the round-robin pointer is removed.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single write: req0 addr=0x1000, data=0xA5.., AXI always ready → ready_o at t; awvalid_o/wvalid_o at t+1 with awid=BASE_ID; IDLE at t+2; bvalid with bid=BASE_ID → req0_bdone_o one cycle later, counter returns to 0.
- Split handshake: awready at t+1, wready held low until t+4 → awvalid_o drops at t+2, wvalid_o stays high to t+4, wdata_o stable; next grant no earlier than t+5.
- Contention: both valid continuously, AXI ready, B returned promptly → grants alternate 0,1,0,1. With CXL_WR_ARB_FIXED_PRIO_EN: grants 0,0,0,0 until req0 deasserts.
- Credit stall: MAX_OUT=4, no B returned → req0 gets exactly 4 grants, then req0_ready_o stays 0 while req1 is still granted; one B for BASE_ID re-enables req0.
- Bad B: bvalid with bid=BASE_ID+5, or bid=BASE_ID+1 with 0 outstanding → bid_err_o=1 and stays 1, no bdone pulse, counters unchanged.
- Reset mid-SEND (awready done, W pending) → next cycle awvalid_o=wvalid_o=0, counters 0, bid_err_o=0, IDLE.
